// File: rtl/sig_bundle_xcvr.sv
// sig_bundle_xcvr: packs an upstream byte stream into six-byte request bundles
// for sub2 (strobe e, tag f, bytes g/h) and replays sub2's returned bundles
// (strobe i, tag j, bytes k/l) downstream as a byte stream, flagging tag errors.
module sig_bundle_xcvr #(
  parameter int MAX_OUT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // upstream byte stream
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte_data,
  output logic             o_byte_ready,
  // request bundle towards sub2
  output logic             o_sig_e,
  output logic [1:0]       o_sig_f,
  output logic [0:2][7:0]  o_sig_g,
  output logic [7:0]       o_sig_h [3],
  // response bundle from sub2
  input  logic             i_sig_i,
  input  logic [1:0]       i_sig_j,
  input  logic [0:2][7:0]  i_sig_k,
  input  logic [7:0]       i_sig_l [3],
  // downstream byte stream
  output logic             o_rsp_valid,
  output logic [7:0]       o_rsp_data,
  input  logic             i_rsp_ready,
  // sticky protocol error
  output logic             o_tag_err
);

  // Counters hold 0..MAX_OUT (at most 4), so three bits always suffice.
  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);
  localparam int         PW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUT - 1);

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // TX side
  // ---------------------------------------------------------------------------
  tx_state_e  state_q, state_d;
  logic [2:0] idx_q;          // byte slot being filled, 0..5
  logic [1:0] slot;           // position of idx_q inside g (0..2) or h (0..2)
  logic       fill_hs;        // upstream byte accepted this cycle
  logic       send_ok;        // room for another outstanding bundle

  // ---------------------------------------------------------------------------
  // RX side
  // ---------------------------------------------------------------------------
  logic [2:0]    outstanding_q;  // bundles sent and not yet fully drained
  logic [2:0]    count_q;        // entries held in the response FIFO
  logic [2:0]    pending;        // bundles sent whose response is still due
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [2:0]    rd_idx_q;       // byte of the head entry being offered, 0..5
  logic [1:0]    exp_tag_q;      // tag the next accepted response should carry
  logic          push;
  logic          pop;
  logic          rsp_hs;
  logic [7:0]    mem [MAX_OUT][6];

  assign send_ok = (outstanding_q < MAX_CNT);
  assign slot    = (idx_q < 3'd3) ? idx_q[1:0] : 2'(idx_q - 3'd3);

  // TX next-state and handshake outputs.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    o_byte_ready = 1'b0;
    o_sig_e      = 1'b0;
    fill_hs      = 1'b0;
    case (state_q)
      FILL: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        o_byte_ready = !i_rst;
        fill_hs      = i_byte_valid;
        if (fill_hs && idx_q == 3'd5) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (send_ok) begin
          o_sig_e = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // TX state register.
  // NOTE: sequential state is only ever updated with non-blocking assignments
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // TX datapath: fill the request slots, advance the byte index and the tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q   <= '0;
      o_sig_f <= '0;
      o_sig_g <= '0;
      o_sig_h <= '{default: '0};
    end else begin
      if (fill_hs) begin
        if (idx_q < 3'd3) begin
          o_sig_g[slot] <= i_byte_data;
        end else begin
          o_sig_h[slot] <= i_byte_data;
        end
        idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      if (o_sig_e) begin
        o_sig_f <= o_sig_f + 2'd1;
        idx_q   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX capture and drain
  // ---------------------------------------------------------------------------
  assign pending     = outstanding_q - count_q;
  assign push        = i_sig_i && (pending != 3'd0);
  assign o_rsp_valid = (count_q != 3'd0);
  assign rsp_hs      = o_rsp_valid && i_rsp_ready;
  assign pop         = rsp_hs && (rd_idx_q == 3'd5);
  // Gated by valid so the unreset storage never reaches the output.
  assign o_rsp_data  = o_rsp_valid ? mem[rd_ptr_q][rd_idx_q] : 8'h00;

  // Response storage write port.
  // NOTE: the storage array has no reset; its contents are only observable
  // through entries counted by count_q, which is reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q][0] <= i_sig_k[0];
      mem[wr_ptr_q][1] <= i_sig_k[1];
      mem[wr_ptr_q][2] <= i_sig_k[2];
      mem[wr_ptr_q][3] <= i_sig_l[0];
      mem[wr_ptr_q][4] <= i_sig_l[1];
      mem[wr_ptr_q][5] <= i_sig_l[2];
    end
  end

  // RX control: pointers, tag checking, sticky error and drain position.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_idx_q  <= '0;
      exp_tag_q <= '0;
      o_tag_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q  <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        exp_tag_q <= exp_tag_q + 2'd1;
        if (i_sig_j != exp_tag_q) begin
          o_tag_err <= 1'b1;
        end
      end
      // A response with nothing pending is dropped and flagged.
      if (i_sig_i && pending == 3'd0) begin
        o_tag_err <= 1'b1;
      end
      if (rsp_hs) begin
        rd_idx_q <= pop ? 3'd0 : rd_idx_q + 3'd1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // Occupancy counters; simultaneous increment and decrement cancel out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      case ({o_sig_e, pop})
        2'b10:   outstanding_q <= outstanding_q + 3'd1;
        2'b01:   outstanding_q <= outstanding_q - 3'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_bundle_xcvr.sv
// tb_sig_bundle_xcvr: directed scenarios with random payloads, checked against
// a queue-based model of the transceiver's bundle/response bookkeeping.
module tb_sig_bundle_xcvr;

  localparam int MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic            sig_e;
  logic [1:0]      sig_f;
  logic [0:2][7:0] sig_g;
  logic [7:0]      sig_h [3];
  logic            sig_i;
  logic [1:0]      sig_j;
  logic [0:2][7:0] sig_k;
  logic [7:0]      sig_l [3];
  logic            rsp_valid;
  logic [7:0]      rsp_data;
  logic            rsp_ready;
  logic            tag_err;

  sig_bundle_xcvr #(.MAX_OUT(MAX_OUT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_byte_valid(byte_valid),
    .i_byte_data (byte_data),
    .o_byte_ready(byte_ready),
    .o_sig_e     (sig_e),
    .o_sig_f     (sig_f),
    .o_sig_g     (sig_g),
    .o_sig_h     (sig_h),
    .i_sig_i     (sig_i),
    .i_sig_j     (sig_j),
    .i_sig_k     (sig_k),
    .i_sig_l     (sig_l),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .i_rsp_ready (rsp_ready),
    .o_tag_err   (tag_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: bundles in flight, tags, and the expected byte stream.
  int              m_out;
  int              m_tag;
  int              m_exp;
  logic            m_err;
  logic [7:0]      exp_q [$];
  logic            held;
  logic [0:5][7:0] held_bb;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_out = 0;
    m_tag = 0;
    m_exp = 0;
    m_err = 1'b0;
    exp_q.delete();
    held  = 1'b0;
  endtask

  function automatic logic [0:5][7:0] rand_bb();
    logic [0:5][7:0] r;
    for (int i = 0; i < 6; i++) r[i] = 8'($urandom);
    return r;
  endfunction

  task automatic do_reset;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    sig_i      = 1'b0;
    rsp_ready  = 1'b0;
    rst        = 1'b1;
    #1;
    check("rst_byte_ready", 32'(byte_ready), 0);
    check("rst_sig_e", 32'(sig_e), 0);
    check("rst_sig_f", 32'(sig_f), 0);
    check("rst_sig_g", 32'(sig_g), 0);
    check("rst_sig_h", 32'({sig_h[0], sig_h[1], sig_h[2]}), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_tag_err", 32'(tag_err), 0);
    tick;
    rst = 1'b0;
    model_reset();
    tick;
    check("byte_ready_after_rst", 32'(byte_ready), 1);
  endtask

  // Request must be on the wire this cycle with the model's tag and bytes.
  task automatic check_fire(input logic [0:5][7:0] bb);
    check("sig_e_fire", 32'(sig_e), 1);
    check("sig_f", 32'(sig_f), 32'(m_tag % 4));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sig_g[%0d]", i), 32'(sig_g[i]), 32'(bb[i]));
      check($sformatf("sig_h[%0d]", i), 32'(sig_h[i]), 32'(bb[i+3]));
    end
    m_out++;
    m_tag++;
    held = 1'b0;
  endtask

  task automatic send_bundle(input logic [0:5][7:0] bb);
    for (int i = 0; i < 6; i++) begin
      check("byte_ready_fill", 32'(byte_ready), 1);
      byte_valid = 1'b1;
      byte_data  = bb[i];
      tick;
    end
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    if (m_out < MAX_OUT) begin
      check_fire(bb);
      tick;
    end else begin
      check("sig_e_blocked", 32'(sig_e), 0);
      held    = 1'b1;
      held_bb = bb;
      for (int c = 0; c < 3; c++) begin
        tick;
        check("sig_e_hold", 32'(sig_e), 0);
        check("byte_ready_hold", 32'(byte_ready), 0);
      end
    end
  endtask

  task automatic respond(input logic [1:0] tag, input logic [0:5][7:0] bb);
    int entries;
    int pending;
    entries = (exp_q.size() + 5) / 6;
    pending = m_out - entries;
    sig_i = 1'b1;
    sig_j = tag;
    for (int i = 0; i < 3; i++) begin
      sig_k[i] = bb[i];
      sig_l[i] = bb[i+3];
    end
    tick;
    sig_i = 1'b0;
    if (pending == 0) begin
      m_err = 1'b1;
    end else begin
      for (int i = 0; i < 6; i++) exp_q.push_back(bb[i]);
      if (int'(tag) != m_exp % 4) m_err = 1'b1;
      m_exp++;
    end
    check("rsp_valid_after_strobe", 32'(rsp_valid), 32'(exp_q.size() > 0));
    check("tag_err_after_strobe", 32'(tag_err), 32'(m_err));
  endtask

  // Accept n bytes; optionally withhold ready for stall_len cycles at stall_at.
  task automatic drain(input int n, input int stall_at, input int stall_len);
    for (int c = 0; c < n; c++) begin
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
      if (c == stall_at) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick;
          check("rsp_valid_stall", 32'(rsp_valid), 1);
          check("rsp_data_stall", 32'(rsp_data), 32'(exp_q[0]));
        end
      end
      rsp_ready = 1'b1;
      tick;
      void'(exp_q.pop_front());
      if (exp_q.size() % 6 == 0) m_out--;
    end
    rsp_ready = 1'b0;
    check("rsp_valid_after_drain", 32'(rsp_valid), 32'(exp_q.size() > 0));
    check("tag_err_after_drain", 32'(tag_err), 32'(m_err));
  endtask

  initial begin
    logic [0:5][7:0] req;
    logic [0:5][7:0] rsp;

    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    sig_i      = 1'b0;
    sig_j      = 2'd0;
    sig_k      = '0;
    sig_l      = '{default: '0};
    rsp_ready  = 1'b0;
    model_reset();
    tick;
    do_reset();

    // Single round trip followed by four more: tags 0,1,2,3,0, no error.
    for (int r = 0; r < 5; r++) begin
      if (r == 0) begin
        req = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rsp = {8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
      end else begin
        req = rand_bb();
        rsp = rand_bb();
      end
      send_bundle(req);
      respond(2'(m_exp), rsp);
      drain(6, -1, 0);
    end
    check("tag_err_after_wrap", 32'(tag_err), 0);

    // TX back-pressure: third bundle waits for a full drain.
    do_reset();
    for (int b = 0; b < 3; b++) send_bundle(rand_bb());
    check("held_third_bundle", 32'(held), 1);
    respond(2'd0, {8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3});
    drain(6, 3, 5);
    if (held && m_out < MAX_OUT) check_fire(held_bb);
    else check("third_fire_model", 32'(held), 0);
    tick;
    respond(2'(m_exp), rand_bb());
    respond(2'(m_exp), rand_bb());
    drain(12, -1, 0);

    // Tag mismatch: data still emitted, error sticky.
    do_reset();
    send_bundle(rand_bb());
    respond(2'd3, rand_bb());
    drain(6, -1, 0);
    tick;
    tick;
    check("tag_err_sticky", 32'(tag_err), 1);

    // Unexpected response with nothing outstanding.
    do_reset();
    respond(2'd0, rand_bb());
    for (int c = 0; c < 2; c++) begin
      tick;
      check("rsp_valid_unexpected", 32'(rsp_valid), 0);
      check("tag_err_unexpected", 32'(tag_err), 1);
    end

    // Mid-bundle reset discards the partial bundle; next bundle carries tag 0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("byte_ready_partial", 32'(byte_ready), 1);
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      tick;
    end
    do_reset();
    send_bundle(rand_bb());
    respond(2'(m_exp), rand_bb());
    drain(6, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
